// File: rtl/relu_pkg.sv
// -----------------------------------------------------------------------------
// relu_pkg
// Shared definitions for the relu_sched scheduler slice: default data width,
// data word typedef, scheduler FSM state encoding and small index helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package relu_pkg;

    // Default half width is 8, so a data word is 16 bits.
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Increment an index modulo n (works for non-power-of-two n).
    function automatic int wrap_inc(input int v, input int n);
        if (v + 1 >= n) begin
            return 0;
        end else begin
            return v + 1;
        end
    endfunction

endpackage

// File: rtl/relu_core.sv
// -----------------------------------------------------------------------------
// relu_core
// Registered ReLU stage: a two's-complement word with the sign bit set becomes
// zero, anything else (including zero) passes through. One cycle latency.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (output clears to 0)
//   din   in   DW-bit input word
//   dout  out  DW-bit registered ReLU result
// -----------------------------------------------------------------------------
module relu_core
    import relu_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] dout_r;

    // ReLU result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= {DW{1'b0}};
        end else if (din[DW-1]) begin
            dout_r <= {DW{1'b0}};
        end else begin
            dout_r <= din;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/relu_sched.sv
// -----------------------------------------------------------------------------
// relu_sched
// Round-robin scheduler sharing one registered ReLU stage among NREQ
// requesters. Bursts are granted atomically (until req_last or MAX_BURST
// beats), results come back tagged with the source ID, and output
// backpressure stalls the pipe without loss or duplication.
// Optional feature macro: RELU_SCHED_STATS_EN adds the clip_cnt port/counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/last    per-requester beat valid / final beat of burst
//   req_data          per-requester data, slice [i*2*WIDTH +: 2*WIDTH]
//   req_ready         one-hot (or zero) beat-accept strobe, combinational
//   out_valid/data    registered ReLU result and its valid
//   out_id/out_last   source requester and end-of-burst flag of the result
//   out_ready         downstream accept
//   clip_cnt          (RELU_SCHED_STATS_EN only) saturating count of
//                     accepted beats with the sign bit set
// -----------------------------------------------------------------------------
module relu_sched
    import relu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*2*WIDTH-1:0]         req_data,
    input  logic [NREQ-1:0]                 req_last,
    output logic [NREQ-1:0]                 req_ready,
    output logic                            out_valid,
    output logic [2*WIDTH-1:0]              out_data,
    output logic [id_width(NREQ)-1:0]       out_id,
    output logic                            out_last,
    input  logic                            out_ready
`ifdef RELU_SCHED_STATS_EN
    ,
    output logic [31:0]                     clip_cnt
`endif
);

    localparam int DW  = 2 * WIDTH;
    localparam int IDW = id_width(NREQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    state_t          state_r, state_nxt_s;
    logic [IDW-1:0]  owner_r, owner_nxt_s;
    logic [IDW-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic [BCW-1:0]  beat_cnt_r, beat_cnt_nxt_s, beats_now_s;
    logic [IDW-1:0]  winner_s, sel_s;
    logic            any_valid_s;
    int              idx_s;
    logic            can_issue_s, xfer_s, forced_s, last_flag_s;
    logic [DW-1:0]   sel_data_s, din_s;
    logic [DW-1:0]   hold_data_r;
    logic [IDW-1:0]  hold_id_r;
    logic            hold_last_r;
    logic            out_valid_r;

    // Round-robin search: scanning offsets high to low leaves the lowest
    // valid offset from rr_ptr as the winner.
    always_comb begin
        winner_s    = rr_ptr_r;
        any_valid_s = 1'b0;
        idx_s       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_s = int'(rr_ptr_r) + i;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            if (req_valid[idx_s]) begin
                winner_s    = IDW'(idx_s);
                any_valid_s = 1'b1;
            end else begin
                winner_s    = winner_s;
            end
        end
    end

    // Selected requester, issue/transfer decision and burst-end detection.
    // Transfers are gated by rst_n so req_ready is zero while reset is held.
    always_comb begin
        if (state_r == LOCK) begin
            sel_s       = owner_r;
            beats_now_s = beat_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
        end else begin
            sel_s       = winner_s;
            beats_now_s = {{(BCW-1){1'b0}}, 1'b1};
        end
        sel_data_s  = req_data[int'(sel_s)*DW +: DW];
        can_issue_s = !out_valid_r || out_ready;
        xfer_s      = rst_n && can_issue_s && req_valid[sel_s];
        forced_s    = (beats_now_s == BCW'(MAX_BURST));
        last_flag_s = req_last[sel_s] || forced_s;
        // During a stall the hold register re-feeds the core so its output
        // is recomputed to the same value.
        if (xfer_s) begin
            din_s = sel_data_s;
        end else begin
            din_s = hold_data_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= {IDW{1'b0}};
            rr_ptr_r   <= {IDW{1'b0}};
            beat_cnt_r <= {BCW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // FSM next-state logic. A single-beat burst granted from IDLE never
    // enters LOCK; it releases straight away.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (!any_valid_s) begin
                    state_nxt_s = IDLE;
                end else if (xfer_s && last_flag_s) begin
                    rr_ptr_nxt_s   = IDW'(wrap_inc(int'(winner_s), NREQ));
                    beat_cnt_nxt_s = {BCW{1'b0}};
                end else begin
                    state_nxt_s    = LOCK;
                    owner_nxt_s    = winner_s;
                    beat_cnt_nxt_s = xfer_s ? beats_now_s : {BCW{1'b0}};
                end
            end
            LOCK: begin
                if (!xfer_s) begin
                    state_nxt_s = LOCK;
                end else if (last_flag_s) begin
                    state_nxt_s    = IDLE;
                    rr_ptr_nxt_s   = IDW'(wrap_inc(int'(owner_r), NREQ));
                    beat_cnt_nxt_s = {BCW{1'b0}};
                end else begin
                    beat_cnt_nxt_s = beats_now_s;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                beat_cnt_nxt_s = {BCW{1'b0}};
            end
        endcase
    end

    // FSM outputs: accept strobe for the selected requester only.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (xfer_s) begin
            req_ready[sel_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Hold register and result valid, aligned with the relu_core register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r <= {DW{1'b0}};
            hold_id_r   <= {IDW{1'b0}};
            hold_last_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            hold_data_r <= sel_data_s;
            hold_id_r   <= sel_s;
            hold_last_r <= last_flag_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    relu_core #(.DW(DW)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din_s),
        .dout  (out_data)
    );

    assign out_valid = out_valid_r;
    assign out_id    = hold_id_r;
    assign out_last  = hold_last_r;

`ifdef RELU_SCHED_STATS_EN
    logic [31:0] clip_cnt_r;

    // Saturating count of accepted negative beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_r <= 32'd0;
        end else if (xfer_s && sel_data_s[DW-1] && (clip_cnt_r != 32'hFFFF_FFFF)) begin
            clip_cnt_r <= clip_cnt_r + 32'd1;
        end else begin
            clip_cnt_r <= clip_cnt_r;
        end
    end

    assign clip_cnt = clip_cnt_r;
`endif

endmodule
